// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the
// bit-period helper used by both the transmit and (future) receive controllers.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Truncating division: the line runs slightly fast rather than slow.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timebase: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick
// on the last count of each bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts one word per frame over valid/ready and
// serialises it as start, data (LSB first), optional parity and stop bits.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_IDLE   | line high, tx_ready asserted, waiting for a word
//   S_START  | driving the start bit (0)
//   S_DATA   | driving shreg[0], one data bit per bit period
//   S_PARITY | driving the precomputed parity bit
//   S_STOP   | driving stop bit(s) (1)
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 1_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int               CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int               BIT_W        = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP    = 1'(STOP_BITS - 1);
    localparam bit               HAS_PARITY   = (PARITY != PAR_NONE);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $fatal(1, "uart_tx_ctrl: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_tx_ctrl: DATA_BITS must be in 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
        $fatal(1, "uart_tx_ctrl: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $fatal(1, "uart_tx_ctrl: STOP_BITS must be 1 or 2");
    end

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic                 par;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic                 bit_tick;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == PAR_ODD) ? ~^d : ^d;
    endfunction

    assign tx_ready = (state == S_IDLE) && !rst;

    // Holding the counter clear in IDLE guarantees a fresh count on START entry;
    // every other state change happens on a tick, which also clears it.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk (clk),
        .rst (rst),
        .clr (state == S_IDLE),
        .en  (state != S_IDLE),
        .tick(bit_tick)
    );

    // tx is loaded with the level of the state being entered, so the pin
    // changes on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            shreg    <= '0;
            par      <= 1'b0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shreg <= tx_data;
                        par   <= parity_of(tx_data);
                        state <= S_START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_tick) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        shreg <= shreg >> 1;
                        if (bit_idx == LAST_BIT) begin
                            if (HAS_PARITY) begin
                                state <= S_PARITY;
                                tx    <= par;
                            end else begin
                                state    <= S_STOP;
                                stop_idx <= 1'b0;
                                tx       <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_tick) begin
                        state    <= S_STOP;
                        stop_idx <= 1'b0;
                        tx       <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        if (stop_idx == LAST_STOP) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: four instances (8N1, 8E1, 8O1, 7N2) at
// 10 clocks per bit, each frame compared bit-by-bit against hand-built vectors.
module tb_uart_tx_ctrl;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic [3:0] valid;
    logic [3:0] txs;
    logic [3:0] readys;
    logic [3:0] busys;
    int         sel;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         starts[$];
    logic       prev_busy0 = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Start-bit times on the 8N1 instance: busy rising with the line low.
    always @(negedge clk) begin
        if (!prev_busy0 && busys[0] && !txs[0]) starts.push_back(cyc);
        prev_busy0 = busys[0];
    end

    uart_tx_ctrl #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[0]),
        .tx_ready(readys[0]), .tx(txs[0]), .busy(busys[0]));

    uart_tx_ctrl #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_even (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[1]),
        .tx_ready(readys[1]), .tx(txs[1]), .busy(busys[1]));

    uart_tx_ctrl #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_odd (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[2]),
        .tx_ready(readys[2]), .tx(txs[2]), .busy(busys[2]));

    uart_tx_ctrl #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_7n2 (
        .clk(clk), .rst(rst), .tx_data(tx_data[6:0]), .tx_valid(valid[3]),
        .tx_ready(readys[3]), .tx(txs[3]), .busy(busys[3]));

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (readys[sel] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (readys[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s wait_ready: tx_ready=%b after %0d cycles, expected 1", name, readys[sel], n);
        end
    endtask

    // Called at a negedge with tx_ready high; returns at the negedge of frame cycle 1.
    task automatic handshake(input logic [7:0] d);
        tx_data    = d;
        valid[sel] = 1'b1;
        @(negedge clk);
        valid[sel] = 1'b0;
    endtask

    // exp holds the line levels in transmit order (exp[0] = start bit).
    // chg_at > 0 drives chg_data with tx_valid high at that frame cycle.
    task automatic check_frame(input string name, input logic [15:0] exp, input int nbits,
                               input int chg_at, input logic [7:0] chg_data);
        int   t;
        int   hs_bad;
        bit   bad;
        logic seen;
        t      = 0;
        hs_bad = 0;
        for (int b = 0; b < nbits; b++) begin
            bad  = 1'b0;
            seen = exp[b];
            for (int c = 0; c < CPB; c++) begin
                t++;
                if (t == chg_at) begin
                    tx_data    = chg_data;
                    valid[sel] = 1'b1;
                end
                if (txs[sel] !== exp[b]) begin
                    bad  = 1'b1;
                    seen = txs[sel];
                end
                if (busys[sel] !== 1'b1 || readys[sel] !== 1'b0) hs_bad++;
                @(negedge clk);
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s bit%0d: tx=%b expected %b for all %0d cycles", name, b, seen, exp[b], CPB);
            end
        end
        checks++;
        if (hs_bad != 0) begin
            errors++;
            $display("FAIL %s in-frame busy/ready: %0d bad cycles, expected 0", name, hs_bad);
        end
        checks++;
        if (readys[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready after frame: got %b expected 1", name, readys[sel]);
        end
        checks++;
        if (busys[sel] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy after frame: got %b expected 0", name, busys[sel]);
        end
        checks++;
        if (txs[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s tx idle after frame: got %b expected 1", name, txs[sel]);
        end
    endtask

    task automatic test_reset();
        sel      = 0;
        valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (readys !== 4'b0000) begin
            errors++;
            $display("FAIL reset ready: got %b expected 0000", readys);
        end
        checks++;
        if (txs !== 4'b1111 || busys !== 4'b0000) begin
            errors++;
            $display("FAIL reset tx/busy: tx=%b busy=%b expected 1111/0000", txs, busys);
        end
        valid[0] = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        checks++;
        if (readys !== 4'b1111 || busys !== 4'b0000 || txs !== 4'b1111) begin
            errors++;
            $display("FAIL reset release: ready=%b busy=%b tx=%b expected 1111/0000/1111", readys, busys, txs);
        end
    endtask

    task automatic test_8n1();
        sel = 0;
        wait_ready("8n1");
        handshake(8'hA5);
        check_frame("8n1_a5", 16'h034A, 10, 0, 8'h00);
    endtask

    task automatic test_parity();
        sel = 1;
        wait_ready("even");
        handshake(8'h07);
        check_frame("even_07", 16'h060E, 11, 0, 8'h00);
        sel = 2;
        wait_ready("odd");
        handshake(8'h07);
        check_frame("odd_07", 16'h040E, 11, 0, 8'h00);
    endtask

    task automatic test_back_to_back();
        sel = 0;
        wait_ready("b2b");
        starts.delete();
        tx_data  = 8'h55;
        valid[0] = 1'b1;
        @(negedge clk);
        tx_data = 8'h0F;
        check_frame("b2b_55", 16'h02AA, 10, 0, 8'h00);
        @(negedge clk);
        valid[0] = 1'b0;
        check_frame("b2b_0f", 16'h021E, 10, 0, 8'h00);
        checks++;
        if (starts.size() != 2) begin
            errors++;
            $display("FAIL b2b start count: got %0d expected 2", starts.size());
        end else if (starts[1] - starts[0] != 101) begin
            errors++;
            $display("FAIL b2b start spacing: got %0d expected 101", starts[1] - starts[0]);
        end
    endtask

    task automatic test_data_stability();
        sel = 0;
        wait_ready("stable");
        handshake(8'h3C);
        check_frame("stable_3c", 16'h0278, 10, 20, 8'hFF);
        valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (busys[0] !== 1'b0 || txs[0] !== 1'b1) begin
            errors++;
            $display("FAIL stable extra handshake: busy=%b tx=%b expected 0/1", busys[0], txs[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        sel = 0;
        wait_ready("rst_mid");
        handshake(8'hA5);
        repeat (34) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (txs[0] !== 1'b1 || busys[0] !== 1'b0 || readys[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid during rst: tx=%b busy=%b ready=%b expected 1/0/0", txs[0], busys[0], readys[0]);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (readys[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid ready after rst: got %b expected 1", readys[0]);
        end
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            if (txs[0] !== 1'b1 || busys[0] !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_mid residual bits: %0d non-idle cycles, expected 0", bad);
        end
        handshake(8'h81);
        check_frame("rst_mid_81", 16'h0302, 10, 0, 8'h00);
    endtask

    task automatic test_7n2();
        sel = 3;
        wait_ready("7n2");
        handshake(8'h7F);
        check_frame("7n2_7f", 16'h03FE, 10, 0, 8'h00);
    endtask

    initial begin
        rst     = 1'b1;
        valid   = 4'b0000;
        tx_data = 8'h00;
        sel     = 0;
        @(negedge clk);
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_data_stability();
        test_reset_mid_frame();
        test_7n2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
